uart_tx_core: RTL and testbench



---
 rtl/uart_pkg.sv | 68 ++++++
 rtl/uart_tx_core_if.sv | 31 +++
 rtl/uart_baud_counter.sv | 47 ++++
 rtl/uart_tx_core.sv | 219 +++++++++++++++++++++
 tb/tb_uart_tx_core.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART datapath (TX core today, RX core later).
//   Holds the serialiser state encoding, the reg2 field codes for parity and
//   stop bits, the legal data-bit range, and small helpers that decode those
//   fields so every core interprets them the same way.
// ---------------------------------------------------------------------------
package uart_pkg;

  // Width of the user byte path.
  localparam int DATA_W = 8;

  // Serialiser states, in frame order.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // reg2 parity field. Code 3 is reserved and behaves like "none".
  typedef enum logic [1:0] {
    PARITY_NONE     = 2'd0,
    PARITY_ODD      = 2'd1,
    PARITY_EVEN     = 2'd2,
    PARITY_NONE_ALT = 2'd3
  } parity_e;

  // reg2 stop field: only this code selects two stop bits.
  localparam logic [1:0] STOP_TWO = 2'd2;

  // Legal data-bit range; programmed values outside it are clamped.
  localparam logic [3:0] DATA_BITS_MIN = 4'd5;
  localparam logic [3:0] DATA_BITS_MAX = 4'd8;

  // Shortest bit period the serialiser will use, in clocks.
  localparam int DEFAULT_MIN_DIV = 2;

  // Clamp the programmed data-bit count into 5..8.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] code);
    logic [3:0] result;
    result = code;
    if (code < DATA_BITS_MIN) begin
      result = DATA_BITS_MIN;
    end else if (code > DATA_BITS_MAX) begin
      result = DATA_BITS_MAX;
    end
    return result;
  endfunction

  // True when the parity field asks for a parity bit.
  function automatic logic parity_enabled(input logic [1:0] code);
    return (code == PARITY_ODD) || (code == PARITY_EVEN);
  endfunction

  // Parity over the low nbits of data. Even parity is the plain XOR, odd
  // parity is its inverse. nbits must already be clamped to 5..8.
  function automatic logic calc_parity(input logic [DATA_W-1:0] data,
                                       input logic [3:0]        nbits,
                                       input logic [1:0]        code);
    logic [DATA_W-1:0] masked;
    // 8'hFF << 8 is zero, so nbits == 8 keeps every bit.
    masked = data & ~(8'hFF << nbits);
    return (^masked) ^ (code == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// ---------------------------------------------------------------------------
// uart_tx_core_if
//   Byte handshake between the UART slave's TX FIFO and the TX serialiser.
//   Signals:
//     i_user_tx_data   byte offered by the upstream (held until accepted)
//     i_user_tx_valid  upstream has a byte
//     o_user_tx_ready  serialiser can take a byte this cycle
//   Modports:
//     master  upstream side (FIFO / bench)
//     slave   serialiser side
// ---------------------------------------------------------------------------
interface uart_tx_core_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] i_user_tx_data;
  logic              i_user_tx_valid;
  logic              o_user_tx_ready;

  modport master (
    output i_user_tx_data,
    output i_user_tx_valid,
    input  o_user_tx_ready
  );

  modport slave (
    input  i_user_tx_data,
    input  i_user_tx_valid,
    output o_user_tx_ready
  );

endinterface

// File: rtl/uart_baud_counter.sv
// ---------------------------------------------------------------------------
// uart_baud_counter
//   Loadable down-counter that marks the last clock of a bit period.
//   Load with (period - 1) on the first clock of a bit; o_tick is high on the
//   clock where the count has reached zero, i.e. the last clock of the period.
//   Ports:
//     clock       system clock
//     reset       asynchronous, active-low
//     i_load      load i_load_val this clock (takes priority over counting)
//     i_load_val  new count value
//     i_enable    count down while high; o_tick is masked while low
//     o_tick      terminal count reached
// ---------------------------------------------------------------------------
module uart_baud_counter #(
  parameter int P_WIDTH = 25
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_load,
  input  logic [P_WIDTH-1:0] i_load_val,
  input  logic               i_enable,
  output logic               o_tick
);

  logic [P_WIDTH-1:0] count_q;
  logic [P_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (i_enable && (count_q != '0)) begin
      count_d = count_q - P_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_tick = i_enable && (count_q == '0);

endmodule

// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
//   UART serialiser. Takes one byte per valid/ready handshake and sends
//   start bit, 5..8 data bits LSB first, optional parity, 1 or 2 stop bits,
//   each bit lasting a programmable number of clocks.
//   Ports:
//     clock        system clock
//     reset        asynchronous, active-low
//     tx_if        byte handshake (slave side)
//     o_uart_tx    serial line, idle high, registered
//     i_uart_cts   peer flow control, asynchronous; high blocks new frames
//     i_div_num    clocks per bit (raised to P_MIN_DIV if smaller)
//     i_data_bit   data bits per frame (clamped to 5..8)
//     i_stop_bit   2 = two stop bits, otherwise one
//     i_check_bit  0/3 = no parity, 1 = odd, 2 = even
//     o_tx_busy    high from acceptance until the stop period ends
//   All configuration is captured at acceptance, so reg2 may change while a
//   frame is on the line without disturbing it.
// ---------------------------------------------------------------------------
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int P_DIV_WIDTH = 24,
  parameter int P_MIN_DIV   = DEFAULT_MIN_DIV
) (
  input  logic                   clock,
  input  logic                   reset,
  uart_tx_core_if.slave          tx_if,
  output logic                   o_uart_tx,
  input  logic                   i_uart_cts,
  input  logic [P_DIV_WIDTH-1:0] i_div_num,
  input  logic [3:0]             i_data_bit,
  input  logic [1:0]             i_stop_bit,
  input  logic [1:0]             i_check_bit,
  output logic                   o_tx_busy
);

  // One extra bit so a two-stop-bit period (2 * eff_div) fits.
  localparam int CW = P_DIV_WIDTH + 1;

  tx_state_e          state_q,     state_d;
  logic               tx_q,        tx_d;
  logic               ready_q,     ready_d;
  logic               busy_q,      busy_d;
  logic               cts_meta_q,  cts_meta_d;
  logic               cts_s_q,     cts_s_d;
  logic [DATA_W-1:0]  shift_q,     shift_d;
  logic [2:0]         bit_idx_q,   bit_idx_d;
  logic [3:0]         nbits_q,     nbits_d;
  logic               two_stop_q,  two_stop_d;
  logic               par_en_q,    par_en_d;
  logic               par_bit_q,   par_bit_d;
  logic [P_DIV_WIDTH-1:0] eff_div_q, eff_div_d;

  logic               accept;
  logic [P_DIV_WIDTH-1:0] eff_div_in;
  logic [3:0]         nbits_in;
  logic [CW-1:0]      bit_len_m1;
  logic [CW-1:0]      stop_len_m1;
  logic               cnt_load;
  logic [CW-1:0]      cnt_load_val;
  logic               cnt_tick;

  assign accept     = tx_if.i_user_tx_valid && ready_q;
  assign eff_div_in = (i_div_num < P_DIV_WIDTH'(P_MIN_DIV)) ? P_DIV_WIDTH'(P_MIN_DIV)
                                                            : i_div_num;
  assign nbits_in   = clamp_data_bits(i_data_bit);

  // Reload values use the captured period, never the live input.
  assign bit_len_m1  = CW'(eff_div_q) - CW'(1);
  assign stop_len_m1 = two_stop_q ? (({1'b0, eff_div_q} << 1) - CW'(1)) : bit_len_m1;

  uart_baud_counter #(
    .P_WIDTH (CW)
  ) u_baud (
    .clock      (clock),
    .reset      (reset),
    .i_load     (cnt_load),
    .i_load_val (cnt_load_val),
    .i_enable   (state_q != ST_IDLE),
    .o_tick     (cnt_tick)
  );

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    nbits_d      = nbits_q;
    two_stop_d   = two_stop_q;
    par_en_d     = par_en_q;
    par_bit_d    = par_bit_q;
    eff_div_d    = eff_div_q;
    cnt_load     = 1'b0;
    cnt_load_val = bit_len_m1;

    // Plain two-flop synchroniser for the asynchronous CTS input.
    cts_meta_d = i_uart_cts;
    cts_s_d    = cts_meta_q;

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d      = ST_START;
          tx_d         = 1'b0;
          busy_d       = 1'b1;
          shift_d      = tx_if.i_user_tx_data;
          nbits_d      = nbits_in;
          two_stop_d   = (i_stop_bit == STOP_TWO);
          par_en_d     = parity_enabled(i_check_bit);
          // Parity is fixed at acceptance from the same snapshot as the data.
          par_bit_d    = calc_parity(tx_if.i_user_tx_data, nbits_in, i_check_bit);
          eff_div_d    = eff_div_in;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(eff_div_in) - CW'(1);
        end
      end

      ST_START: begin
        if (cnt_tick) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          cnt_load  = 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_tick) begin
          cnt_load = 1'b1;
          if ({1'b0, bit_idx_q} == (nbits_q - 4'd1)) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d      = ST_STOP;
              tx_d         = 1'b1;
              cnt_load_val = stop_len_m1;
            end
          end else begin
            // shift_q[0] is on the line now, so the next bit is shift_q[1].
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[DATA_W-1:1]};
            tx_d      = shift_q[1];
          end
        end
      end

      ST_PARITY: begin
        if (cnt_tick) begin
          state_d      = ST_STOP;
          tx_d         = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = stop_len_m1;
        end
      end

      ST_STOP: begin
        tx_d = 1'b1;
        if (cnt_tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Looking at the next state lets ready rise on the same edge the stop
    // period ends, and drop on the accepting edge. A new byte can therefore
    // be taken one clock after the stop period at the earliest, which is the
    // one-clock idle gap between back-to-back frames.
    ready_d = (state_d == ST_IDLE) && !cts_s_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      // Treat the peer as blocked until the synchroniser has filled.
      cts_meta_q <= 1'b1;
      cts_s_q    <= 1'b1;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      nbits_q    <= DATA_BITS_MAX;
      two_stop_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      eff_div_q  <= P_DIV_WIDTH'(P_MIN_DIV);
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      cts_meta_q <= cts_meta_d;
      cts_s_q    <= cts_s_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      nbits_q    <= nbits_d;
      two_stop_q <= two_stop_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      eff_div_q  <= eff_div_d;
    end
  end

  assign o_uart_tx             = tx_q;
  assign o_tx_busy             = busy_q;
  assign tx_if.o_user_tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_core.sv
`timescale 1ns/1ps
module tb_uart_tx_core;

  localparam int DW = 24;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          uart_tx;
  logic          uart_cts;
  logic          tx_busy;
  logic [DW-1:0] div_num;
  logic [3:0]    data_bit;
  logic [1:0]    stop_bit;
  logic [1:0]    check_bit;

  uart_tx_core_if tx_if ();

  uart_tx_core #(
    .P_DIV_WIDTH (DW),
    .P_MIN_DIV   (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tx_if       (tx_if),
    .o_uart_tx   (uart_tx),
    .i_uart_cts  (uart_cts),
    .i_div_num   (div_num),
    .i_data_bit  (data_bit),
    .i_stop_bit  (stop_bit),
    .i_check_bit (check_bit),
    .o_tx_busy   (tx_busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Expected line level for every clock of every accepted frame.
  logic exp_q[$];
  int   acc_count = 0;
  int   acc_cyc[$];
  int   cyc = 0;
  int   log_idx = 0;
  logic log_tx   [0:1023];
  logic log_busy [0:1023];
  logic log_rdy  [0:1023];

  function automatic void emit(input logic level, input int clocks);
    for (int i = 0; i < clocks; i++) exp_q.push_back(level);
  endfunction

  function automatic void push_frame(input logic [7:0] data, input int div,
                                     input int db, input int sb, input int cb);
    int   d, n, s;
    logic par;
    d   = (div < 2) ? 2 : div;
    n   = (db < 5) ? 5 : ((db > 8) ? 8 : db);
    s   = (sb == 2) ? 2 : 1;
    par = (cb == 1);
    for (int i = 0; i < n; i++) par = par ^ data[i];
    emit(1'b0, d);
    for (int i = 0; i < n; i++) emit(data[i], d);
    if (cb == 1 || cb == 2) emit(par, d);
    emit(1'b1, s * d);
  endfunction

  always @(posedge clock) begin
    cyc++;
    if (!reset) begin
      exp_q.delete();
    end else if (tx_if.i_user_tx_valid && tx_if.o_user_tx_ready) begin
      push_frame(tx_if.i_user_tx_data, int'(div_num), int'(data_bit),
                 int'(stop_bit), int'(check_bit));
      acc_count++;
      acc_cyc.push_back(cyc);
      log_idx = 0;
    end
  end

  // Per-cycle compare against the model, plus a log of the latest frame.
  always @(negedge clock) begin
    logic e;
    if (!reset) begin
      exp_q.delete();
      chk("rst_line", uart_tx, 1);
      chk("rst_ready", tx_if.o_user_tx_ready, 0);
      chk("rst_busy", tx_busy, 0);
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("line", uart_tx, e);
      chk("busy_in_frame", tx_busy, 1);
      chk("ready_in_frame", tx_if.o_user_tx_ready, 0);
    end else begin
      chk("line_idle", uart_tx, 1);
      chk("busy_idle", tx_busy, 0);
    end
    if (log_idx < 1024) begin
      log_tx[log_idx]   = uart_tx;
      log_busy[log_idx] = tx_busy;
      log_rdy[log_idx]  = tx_if.o_user_tx_ready;
      log_idx++;
    end
  end

  function automatic logic [15:0] line_bits(input int d, input int nb);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < nb; k++) v[k] = log_tx[k * d + d / 2];
    return v;
  endfunction

  function automatic int busy_len();
    int n;
    n = 0;
    while (n < 1024 && log_busy[n] === 1'b1) n++;
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_accept(input int max_cyc);
    int start, k;
    start = acc_count;
    k = 0;
    while (acc_count == start && k < max_cyc) begin
      step();
      k++;
    end
    chk("accept_seen", acc_count != start, 1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    while (tx_busy && k < max_cyc) begin
      step();
      k++;
    end
    chk("frame_done", tx_busy, 0);
  endtask

  task automatic set_cfg(input logic [7:0] data, input int div, input int db,
                         input int sb, input int cb);
    tx_if.i_user_tx_data = data;
    div_num   = DW'(div);
    data_bit  = 4'(db);
    stop_bit  = 2'(sb);
    check_bit = 2'(cb);
  endtask

  task automatic send(input logic [7:0] data, input int div, input int db,
                      input int sb, input int cb);
    set_cfg(data, div, db, sb, cb);
    tx_if.i_user_tx_valid = 1'b1;
    wait_accept(50);
    tx_if.i_user_tx_valid = 1'b0;
    wait_idle(2000);
  endtask

  task automatic check_ready_after_release();
    step(); chk("ready_edge1", tx_if.o_user_tx_ready, 0);
    step(); chk("ready_edge2", tx_if.o_user_tx_ready, 0);
    step(); chk("ready_edge3", tx_if.o_user_tx_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, k, n0;
    uart_cts = 1'b0;
    tx_if.i_user_tx_valid = 1'b0;
    set_cfg(8'h00, 4, 8, 1, 0);

    // Reset state and ready timing after release.
    repeat (3) step();
    chk("reset_tx", uart_tx, 1);
    chk("reset_ready", tx_if.o_user_tx_ready, 0);
    chk("reset_busy", tx_busy, 0);
    reset = 1'b1;
    check_ready_after_release();

    // 8N1, div 4, 0x55.
    send(8'h55, 4, 8, 1, 0);
    $display("8N1 0x55 div4: bits=0x%0h busy=%0d", line_bits(4, 10), busy_len());
    chk("8N1_bits", line_bits(4, 10), 16'h02AA);
    chk("8N1_busy_len", busy_len(), 40);
    chk("8N1_idle_after", log_tx[40], 1);
    chk("8N1_ready_back", log_rdy[40], 1);

    // Parity cases.
    send(8'h00, 3, 8, 1, 1);
    $display("8O1 0x00: parity=%0b", log_tx[28]);
    chk("8O1_parity", log_tx[28], 1);
    chk("8O1_busy_len", busy_len(), 33);
    send(8'h07, 3, 8, 1, 2);
    $display("8E1 0x07: parity=%0b", log_tx[28]);
    chk("8E1_07_parity", log_tx[28], 1);
    send(8'h03, 3, 8, 1, 2);
    $display("8E1 0x03: parity=%0b", log_tx[28]);
    chk("8E1_03_parity", log_tx[28], 0);

    // 7E2, div 2, 0xFF; then 7N1 0x80 shows bit 7 is never sent.
    send(8'hFF, 2, 7, 2, 2);
    $display("7E2 0xFF: bits=0x%0h busy=%0d", line_bits(2, 11), busy_len());
    chk("7E2_bits", line_bits(2, 11), 16'h07FE);
    chk("7E2_busy_len", busy_len(), 22);
    send(8'h80, 2, 7, 1, 0);
    $display("7N1 0x80: bits=0x%0h", line_bits(2, 9));
    chk("7N1_bit7_dropped", line_bits(2, 9), 16'h0100);

    // Data-bit clamping.
    send(8'hFF, 2, 3, 1, 0);
    $display("db=3: busy=%0d", busy_len());
    chk("clamp_low_len", busy_len(), 14);
    send(8'hFF, 2, 12, 1, 0);
    $display("db=12: busy=%0d", busy_len());
    chk("clamp_high_len", busy_len(), 20);

    // div 0 -> 2 clocks per bit.
    send(8'h01, 0, 8, 1, 0);
    $display("div0 0x01: bits=0x%0h busy=%0d", line_bits(2, 10), busy_len());
    chk("div0_bits", line_bits(2, 10), 16'h0202);
    chk("div0_busy_len", busy_len(), 20);

    // CTS blocking at idle, release latency, CTS raised mid-frame.
    uart_cts = 1'b1;
    repeat (3) step();
    set_cfg(8'hA5, 4, 8, 1, 0);
    tx_if.i_user_tx_valid = 1'b1;
    start = acc_count;
    repeat (10) begin
      step();
      chk("cts_block_ready", tx_if.o_user_tx_ready, 0);
    end
    chk("cts_no_accept", acc_count, start);
    uart_cts = 1'b0;
    k = 0;
    while (!tx_if.o_user_tx_ready && k < 6) begin
      step();
      k++;
    end
    $display("CTS release: ready after %0d clk", k);
    chk("cts_release_latency", k, 3);
    wait_accept(10);
    tx_if.i_user_tx_data = 8'h3C;
    repeat (8) step();
    uart_cts = 1'b1;
    wait_idle(200);
    start = acc_count;
    repeat (10) begin
      step();
      chk("cts_hold_ready", tx_if.o_user_tx_ready, 0);
    end
    chk("cts_next_held", acc_count, start);
    uart_cts = 1'b0;
    wait_accept(10);
    tx_if.i_user_tx_valid = 1'b0;
    wait_idle(200);
    $display("CTS frame 0x3C sent after release: busy=%0d", busy_len());
    chk("cts_late_frame_len", busy_len(), 40);

    // Back-to-back with config changed mid-frame.
    set_cfg(8'h11, 4, 8, 1, 0);
    n0 = acc_cyc.size();
    tx_if.i_user_tx_valid = 1'b1;
    wait_accept(10);
    tx_if.i_user_tx_data = 8'h22;
    div_num   = DW'(6);
    check_bit = 2'd2;
    wait_accept(100);
    tx_if.i_user_tx_data = 8'h33;
    wait_accept(100);
    tx_if.i_user_tx_valid = 1'b0;
    wait_idle(200);
    if (acc_cyc.size() >= n0 + 3) begin
      $display("b2b: gap1=%0d gap2=%0d", acc_cyc[n0+1] - acc_cyc[n0], acc_cyc[n0+2] - acc_cyc[n0+1]);
      chk("b2b_gap1", acc_cyc[n0+1] - acc_cyc[n0], 41);
      chk("b2b_gap2", acc_cyc[n0+2] - acc_cyc[n0+1], 67);
    end else begin
      chk("b2b_frames", acc_cyc.size() - n0, 3);
    end
    chk("b2b_last_len", busy_len(), 66);

    // Reset mid-DATA.
    set_cfg(8'hF0, 8, 8, 1, 0);
    tx_if.i_user_tx_valid = 1'b1;
    wait_accept(10);
    tx_if.i_user_tx_valid = 1'b0;
    repeat (20) step();
    chk("pre_rst_busy", tx_busy, 1);
    chk("pre_rst_line", uart_tx, 0);
    #1 reset = 1'b0;
    #1;
    $display("reset mid-frame: tx=%0b ready=%0b busy=%0b", uart_tx, tx_if.o_user_tx_ready, tx_busy);
    chk("abort_tx", uart_tx, 1);
    chk("abort_ready", tx_if.o_user_tx_ready, 0);
    chk("abort_busy", tx_busy, 0);
    repeat (3) step();
    reset = 1'b1;
    check_ready_after_release();
    send(8'h5A, 4, 8, 1, 0);
    $display("post-reset 0x5A: bits=0x%0h", line_bits(4, 10));
    chk("post_rst_bits", line_bits(4, 10), 16'h02B4);

    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
